// File: rtl/proc_pkg.sv
// Shared types for the store write buffer: default widths, FSM states
// and the buffered-store record.
package proc_pkg;

    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        RUN,
        FENCE,
        DONE
    } wb_state_t;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } store_entry_t;

endpackage

// File: rtl/wb_match.sv
// Youngest-match search over buffered stores, scanning backward from
// wr_ptr-1 so the most recent store to an address wins.
module wb_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic [DEPTH-1:0]             valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
    input  logic [$clog2(DEPTH)-1:0]     wr_ptr,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         hit,
    output logic [$clog2(DEPTH)-1:0]     index
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    // Oldest slot first; a later (younger) match overrides an earlier one.
    always_comb begin
        hit   = 1'b0;
        index = '0;
        idx   = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = wr_ptr - PTR_W'(i);
            if (valid[idx] && addrs[idx] == ld_addr) begin
                hit   = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// In-order store write buffer between MEM and data memory with fence drain.
// Define FORWARDING_EN to forward buffered data to loads instead of stalling.
module store_write_buffer
    import proc_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_stall,
    input  logic                     mem_busy,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     fence_req,
    output logic                     fence_done,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic [CNT_W-1:0]             count_q;
    wb_state_t                    state;
    wb_state_t                    state_next;
    logic                         fence_hold;
    logic                         push;
    logic                         pop;
    logic                         match_hit;
    logic [PTR_W-1:0]             match_idx;

    assign push      = st_valid && st_ready;
    assign pop       = mem_we;
    assign mem_we    = (count_q != '0) && !mem_busy;
    assign mem_addr  = addr_q[rd_ptr];
    assign mem_wdata = data_q[rd_ptr];
    assign count     = count_q;

    always_comb begin
        state_next = state;
        st_ready   = 1'b0;
        fence_done = 1'b0;
        unique case (state)
            RUN: begin
                st_ready = count_q < CNT_W'(DEPTH);
                if (fence_req && !fence_hold)
                    state_next = FENCE;
            end
            FENCE: begin
                if (count_q == '0)
                    state_next = DONE;
            end
            DONE: begin
                fence_done = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            fence_hold <= 1'b0;
            valid_q    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
        end else begin
            state <= state_next;
            // A level fence_req must drop before it can start another fence.
            if (!fence_req)
                fence_hold <= 1'b0;
            else if (state == DONE)
                fence_hold <= 1'b1;
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr;
            data_q[wr_ptr] <= st_data;
        end
    end

    wb_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_match (
        .valid   (valid_q),
        .addrs   (addr_q),
        .wr_ptr  (wr_ptr),
        .ld_addr (ld_addr),
        .hit     (match_hit),
        .index   (match_idx)
    );

`ifdef FORWARDING_EN
    assign ld_hit   = ld_valid && match_hit;
    assign ld_data  = ld_hit ? data_q[match_idx] : '0;
    assign ld_stall = 1'b0;
`else
    logic unused_idx;
    assign unused_idx = ^match_idx;
    assign ld_hit     = 1'b0;
    assign ld_data    = '0;
    assign ld_stall   = ld_valid && match_hit;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Random + directed bench for store_write_buffer against a queue model.
module tb_store_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [7:0]  st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [7:0]  ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        mem_busy;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        fence_req;
    logic        fence_done;
    logic [2:0]  count;

    store_write_buffer #(.DEPTH(4), .ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .ld_stall   (ld_stall),
        .mem_busy   (mem_busy),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .fence_req  (fence_req),
        .fence_done (fence_done),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } ent_t;

    // Model: queue in program order, fence phase 0=run 1=draining 2=done.
    ent_t q[$];
    int   phase = 0;
    bit   hold  = 0;
    bit   e_ready;
    bit   e_we;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drv(input logic sv, input logic [7:0] sa,
                       input logic [31:0] sd, input logic lv,
                       input logic [7:0] la, input logic b,
                       input logic f, input logic r);
        st_valid  = sv;
        st_addr   = sa;
        st_data   = sd;
        ld_valid  = lv;
        ld_addr   = la;
        mem_busy  = b;
        fence_req = f;
        rst       = r;
    endtask

    task automatic idle();
        drv(0, 8'h0, 32'h0, 0, 8'h0, 0, 0, 0);
    endtask

    // Compare every output against the model at the falling edge.
    task automatic settle();
        bit          m;
        logic [31:0] md;
        int          n;
        @(negedge clk);
        #1;
        n       = q.size();
        e_ready = (n < DEPTH) && (phase == 0);
        e_we    = (n != 0) && !mem_busy;
        m       = 0;
        md      = '0;
        foreach (q[i]) begin
            if (q[i].a == ld_addr) begin
                m  = 1;
                md = q[i].d;
            end
        end
        if (!ld_valid) m = 0;
        chk("count", 32'(count), 32'(n));
        chk("st_ready", 32'(st_ready), 32'(e_ready));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("fence_done", 32'(fence_done), 32'(phase == 2));
        if (e_we) begin
            chk("mem_addr", 32'(mem_addr), 32'(q[0].a));
            chk("mem_wdata", mem_wdata, q[0].d);
        end
`ifdef FORWARDING_EN
        chk("ld_hit", 32'(ld_hit), 32'(m));
        chk("ld_stall", 32'(ld_stall), 32'(0));
        if (m) chk("ld_data", ld_data, md);
`else
        chk("ld_hit", 32'(ld_hit), 32'(0));
        chk("ld_stall", 32'(ld_stall), 32'(m));
        chk("ld_data", ld_data, 32'h0);
`endif
    endtask

    task automatic commit();
        int   n0;
        int   ph0;
        ent_t e;
        @(posedge clk);
        n0  = q.size();
        ph0 = phase;
        if (rst) begin
            q.delete();
            phase = 0;
            hold  = 0;
        end else begin
            if (e_we) void'(q.pop_front());
            if (st_valid && e_ready) begin
                e.a = st_addr;
                e.d = st_data;
                q.push_back(e);
            end
            case (ph0)
                0: if (fence_req && !hold) phase = 1;
                1: if (n0 == 0) phase = 2;
                default: phase = 0;
            endcase
            if (!fence_req) hold = 0;
            else if (ph0 == 2) hold = 1;
        end
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            idle();
            settle();
            if (count == 0) done = 1;
            commit();
        end
        if (!done) chk("drain_timeout", 32'(count), 32'h0);
    endtask

    initial begin
        drv(0, 8'h0, 32'h0, 0, 8'h0, 0, 0, 1);
        settle();
        commit();
        commit();

        // reset state
        idle();
        settle();
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ready", 32'(st_ready), 32'h1);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_hit", 32'(ld_hit), 32'h0);
        chk("rst_done", 32'(fence_done), 32'h0);
        commit();

        // single store reaches memory next cycle
        drv(1, 8'h10, 32'hAA, 0, 8'h0, 0, 0, 0);
        settle();
        chk("t1_we_same", 32'(mem_we), 32'h0);
        commit();
        idle();
        settle();
        chk("t1_count1", 32'(count), 32'h1);
        chk("t1_we", 32'(mem_we), 32'h1);
        chk("t1_addr", 32'(mem_addr), 32'h10);
        chk("t1_data", mem_wdata, 32'hAA);
        commit();
        settle();
        chk("t1_count0", 32'(count), 32'h0);
        commit();

        // fill while busy, fifth store held until the first pop
        for (int i = 0; i < 4; i++) begin
            drv(1, 8'(8'h30 + i), 32'(32'h100 + i), 0, 8'h0, 1, 0, 0);
            settle();
            commit();
        end
        drv(1, 8'h34, 32'h104, 0, 8'h0, 1, 0, 0);
        settle();
        chk("t2_full_ready", 32'(st_ready), 32'h0);
        chk("t2_full_count", 32'(count), 32'h4);
        commit();
        drv(1, 8'h34, 32'h104, 0, 8'h0, 0, 0, 0);
        settle();
        chk("t2_pop_addr", 32'(mem_addr), 32'h30);
        chk("t2_pop_ready", 32'(st_ready), 32'h0);
        commit();
        settle();
        chk("t2_after_ready", 32'(st_ready), 32'h1);
        chk("t2_after_count", 32'(count), 32'h3);
        commit();
        drain();

        // two stores to one address then a load of it
        drv(1, 8'h20, 32'h11, 0, 8'h0, 1, 0, 0);
        settle();
        commit();
        drv(1, 8'h20, 32'h22, 0, 8'h0, 1, 0, 0);
        settle();
        commit();
        drv(0, 8'h0, 32'h0, 1, 8'h20, 1, 0, 0);
        settle();
`ifdef FORWARDING_EN
        chk("t3_hit", 32'(ld_hit), 32'h1);
        chk("t3_data", ld_data, 32'h22);
`else
        chk("t3_stall", 32'(ld_stall), 32'h1);
`endif
        commit();
        for (int k = 0; k < 3; k++) begin
            drv(0, 8'h0, 32'h0, 1, 8'h20, 0, 0, 0);
            settle();
            commit();
        end
        drv(0, 8'h0, 32'h0, 1, 8'h20, 0, 0, 0);
        settle();
        chk("t3_clear_stall", 32'(ld_stall), 32'h0);
        commit();

        // steady push+pop at count 2 through three pointer wraps
        for (int i = 0; i < 2; i++) begin
            drv(1, 8'(8'h40 + i), 32'(32'h200 + i), 0, 8'h0, 1, 0, 0);
            settle();
            commit();
        end
        for (int k = 0; k < 12; k++) begin
            drv(1, 8'(8'h50 + k), 32'(32'h300 + k), 1, 8'(8'h50 + k), 0, 0, 0);
            settle();
            chk("t4_count", 32'(count), 32'h2);
            commit();
        end
        drain();

        // fence with three pending stores
        for (int i = 0; i < 3; i++) begin
            drv(1, 8'(8'h60 + i), 32'(32'h400 + i), 0, 8'h0, 1, 0, 0);
            settle();
            commit();
        end
        drv(0, 8'h0, 32'h0, 0, 8'h0, 1, 1, 0);
        settle();
        commit();
        begin
            bit zero;
            zero = 0;
            for (int k = 0; k < 10 && !zero; k++) begin
                drv(1, 8'h70, 32'h500, 0, 8'h0, 0, 0, 0);
                settle();
                chk("t5_ready_fence", 32'(st_ready), 32'h0);
                if (count == 0) zero = 1;
                chk("t5_done_early", 32'(fence_done), 32'h0);
                commit();
            end
            if (!zero) chk("t5_timeout", 32'(count), 32'h0);
        end
        settle();
        chk("t5_done", 32'(fence_done), 32'h1);
        chk("t5_ready_done", 32'(st_ready), 32'h0);
        commit();
        settle();
        chk("t5_done_off", 32'(fence_done), 32'h0);
        chk("t5_ready_back", 32'(st_ready), 32'h1);
        commit();
        drain();

        // level fence held high on an empty buffer
        for (int k = 0; k < 6; k++) begin
            drv(0, 8'h0, 32'h0, 0, 8'h0, 0, 1, 0);
            settle();
            if (k == 2) chk("lvl_done", 32'(fence_done), 32'h1);
            if (k == 4) chk("lvl_no_refire", 32'(st_ready), 32'h1);
            commit();
        end

        // reset with pending entries
        for (int i = 0; i < 3; i++) begin
            drv(1, 8'(8'h80 + i), 32'(32'h600 + i), 0, 8'h0, 1, 0, 0);
            settle();
            commit();
        end
        drv(0, 8'h0, 32'h0, 0, 8'h0, 1, 0, 1);
        settle();
        commit();
        drv(0, 8'h0, 32'h0, 1, 8'h80, 0, 0, 0);
        settle();
        chk("t6_count", 32'(count), 32'h0);
        chk("t6_we", 32'(mem_we), 32'h0);
        chk("t6_ready", 32'(st_ready), 32'h1);
        chk("t6_hit", 32'(ld_hit), 32'h0);
        chk("t6_stall", 32'(ld_stall), 32'h0);
        commit();

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            drv(1'($urandom_range(0, 1)),
                8'($urandom_range(0, 7)),
                $urandom,
                1'($urandom_range(0, 1)),
                8'($urandom_range(0, 7)),
                ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 99) < 3),
                ($urandom_range(0, 199) == 0));
            settle();
            commit();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
FIFO write buffer between the MEM stage and the data memory write port.
- Store instructions (EX_MEM_MemWrite) retire into the buffer in one cycle, so the pipeline does not wait on memory.
- Entries drain in order to data memory whenever the memory port is not taken by a load.
- This is the writer-side counterpart of the LW read path: loads check the buffer so they never return stale data.

Parameters:
DEPTH, 4, number of buffered stores (power of two, ≥2)
ADDR_W, 8, data-memory word address width
DATA_W, 32, store data width

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
st_valid  in  1  MEM stage presents a store this cycle
st_addr  in  ADDR_W  store word address (EX_MEM_ALUResult low bits)
st_data  in  DATA_W  store data (EX_MEM_WriteData)
st_ready  out  1  buffer can accept a store this cycle
ld_valid  in  1  MEM stage presents a load this cycle (EX_MEM_MemRead)
ld_addr  in  ADDR_W  load word address
ld_hit  out  1  buffered data satisfies the load (forwarding)
ld_data  out  DATA_W  forwarded data, valid when ld_hit
ld_stall  out  1  load must wait; a matching store is pending and cannot be forwarded
mem_busy  in  1  data-memory port used by a load this cycle
mem_we  out  1  write strobe to data memory
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
fence_req  in  1  request full drain (pulse or level)
fence_done  out  1  one-cycle pulse when the fence completes
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=1 at a clock edge):
  - wr_ptr=rd_ptr=count=0; all entry valid bits 0; state=RUN.
  - Outputs: st_ready=1, mem_we=0, ld_hit=0, ld_stall=0, fence_done=0.
  - Reset mid-drain discards all pending entries; this is a documented loss.
- Push: st_valid && st_ready → write entry[wr_ptr], set its valid bit, wr_ptr+1 (mod DEPTH).
- st_ready = (count<DEPTH) && state==RUN. There is no same-cycle bypass when full; a pop in that cycle frees the slot for the next cycle.
- Pop (combinational drive): mem_we = (count!=0) && !mem_busy. mem_addr/mem_wdata = entry[rd_ptr].
  - On that edge: clear the valid bit, rd_ptr+1 (mod DEPTH).
- Minimum latency: a store pushed in cycle N reaches memory no earlier than cycle N+1.
- Push and pop in the same cycle leave count unchanged. Pointers wrap naturally at DEPTH.
- Load lookup (combinational, only when ld_valid):
  - Compares ld_addr against every valid entry.
  - Youngest match wins, searching from wr_ptr-1 backward.
  - The same-cycle incoming store is excluded from the search.
  - An entry being popped this cycle still counts as a match.
- mem_busy=1 blocks draining; a load and a drain never share the port.
- Entries are never coalesced. Two stores to the same address both write memory, in program order.
- State machine:
  - RUN: normal. fence_req → FENCE.
  - FENCE: st_ready=0; drain continues. When count==0 → DONE.
  - DONE: fence_done=1 for one cycle → RUN. If fence_req is still high, go → FENCE again only after fence_req deasserts and re-asserts (edge-detected).
- fence_req while count==0 in RUN: FENCE→DONE in consecutive cycles, so fence_done appears 2 cycles after the request.
- st_valid while st_ready=0: the store is not accepted. The pipeline must hold it; the upstream stall uses !st_ready.

Optional Feature:
FORWARDING_EN
- Defined:
  - Lookup match → ld_hit=1, ld_data=youngest matching entry, ld_stall=0.
  - No match → ld_hit=0, ld_stall=0.
- Undefined:
  - ld_hit=0 and ld_data=0 always.
  - Any match → ld_stall=1 until no matching entry remains. Draining proceeds only on cycles with mem_busy=0, so the pipeline must drop the load's memory access (mem_busy=0) while stalled.

Decomposition:
- Shared package (proc_pkg): ADDR_W/DATA_W defaults; state encoding typedef wb_state_t {RUN, FENCE, DONE}; store_entry_t {valid, addr, data}.
- One natural sub-module: wb_match, a combinational youngest-match priority search over entries.
  - Inputs: entry array, wr_ptr, ld_addr.
  - Outputs: hit and index.

Test Plan:
1. Store addr 0x10 data 0x0000_00AA with mem_busy=0 → mem_we=1 next cycle with addr 0x10 / data 0xAA; count 1→0.
2. mem_busy=1 held; 5 stores (DEPTH=4) → first 4 accepted, count=4, st_ready=0 on the 5th; release mem_busy → drains in order, 5th accepted the cycle after the first pop.
3. Stores 0x20←0x11 then 0x20←0x22, mem_busy=1, load 0x20 → FORWARDING_EN: ld_hit=1, ld_data=0x22; without: ld_stall=1 until both entries are written.
4. Push and pop the same cycle at count=2 → count stays 2, pointers wrap correctly through 3 full wraps.
5. 3 stores pending, fence_req pulse → st_ready=0, fence_done pulses exactly 1 cycle after count reaches 0, then st_ready=1.
6. rst asserted with 3 pending entries → next cycle count=0, mem_we=0, st_ready=1, ld_hit=0.
